water_supply_scheduler: RTL and testbench
=========================================

# water_supply_scheduler

Sequences the water-supply valve over time. Raw level/conflict sensor lines are debounced; the valve opens only on a clean low-level reading and closes on high level or sensor conflict. A minimum closed hold-off protects the valve, and a maximum fill time latches a fault (stuck sensor or leak). It sits between the level-sensor conditioning logic and the valve driver and replaces the purely combinational valve gating.

## Interface
- DEBOUNCE_CYCLES, 4, consecutive stable samples before a filtered sensor value changes (≥1)
- MIN_OFF_CYCLES, 16, minimum cycles the valve stays closed in HOLDOFF after any close (≥1)
- MAX_ON_CYCLES, 1024, maximum continuous open cycles before FAULT (≥2)

Ports:
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high; dominates every other input
- valvule  out  1  1 = valve open; registered
- fault  out  1  1 = fill timeout latched; registered
- water_sensors_conflicting  in  1  raw conflict flag from the sensor checker
- high_water_level  in  1  raw high-level sensor
- low_water_level  in  1  raw low-level sensor
- fault_clear  in  1  single-cycle request to leave FAULT

## Operation
- Debounce, per input (conflicting, high, low):
  - counter increments while raw ≠ filtered and clears when raw = filtered;
  - on the edge where the counter equals DEBOUNCE_CYCLES-1 and raw still differs, filtered ← raw and the counter clears.
- Filtered reset values: conflicting=1, high=0, low=0. The valve therefore cannot open until DEBOUNCE_CYCLES clean samples follow reset.
- open_ok = f_low & ~f_high & ~f_conflicting (filtered only).
- close_now = water_sensors_conflicting | high_water_level (raw, undebounced: safety closes are never delayed).
- FSM, 2-bit state:
  - IDLE: valvule=0. Go to FILLING when open_ok.
  - FILLING: valvule=1; on_count starts at 0 on entry and increments each cycle.
    - close_now → HOLDOFF (highest priority).
    - Otherwise, on_count = MAX_ON_CYCLES-1 → FAULT.
  - HOLDOFF: valvule=0; off_count starts at 0 on entry. Go to IDLE on the edge where off_count = MIN_OFF_CYCLES-1.
    - Raw inputs are ignored here and counting continues.
  - FAULT: valvule=0, fault=1. Go to HOLDOFF when fault_clear & ~water_sensors_conflicting; otherwise stay.
- valvule = (state == FILLING); fault = (state == FAULT). Both are decoded from the state register with no combinational input path.
- Counter widths: $clog2 of the respective parameter + 1. Counters saturate and never wrap; they hold 0 outside their own state.
- fault_clear outside FAULT has no effect.

## Timing
- Reset: state=IDLE, valvule=0, fault=0, all counters 0, filtered values at their reset values. A reset mid-fill closes the valve on that edge.
- Close latency: raw high or conflict sampled at edge k → valvule=0 after edge k.
- Open latency: raw low rises and stays stable before edge 1 → f_low=1 after edge DEBOUNCE_CYCLES → valvule=1 after edge DEBOUNCE_CYCLES+1.
- Minimum off time: MIN_OFF_CYCLES cycles in HOLDOFF plus ≥1 cycle in IDLE.
- Maximum on time: exactly MAX_ON_CYCLES cycles of valvule=1.
- Simultaneous events:
  - close_now and timeout on the same edge → HOLDOFF, no fault.
  - fault_clear with conflicting=1 → stay in FAULT.
- Glitches: a raw glitch shorter than DEBOUNCE_CYCLES never changes filtered values, but a raw high/conflict glitch still closes the valve (intended).

## Structure
- Package water_supply_pkg:
  - state encoding: IDLE=2'd0, FILLING=2'd1, HOLDOFF=2'd2, FAULT=2'd3;
  - parameter defaults.
- Sub-module water_level_debouncer: parameter DEBOUNCE_CYCLES and RESET_VALUE; ports clock, reset, raw, filtered. Instantiated three times.
- Top module contains the FSM, on_count, off_count and output decode.

## Test plan
- Reset, then conflicting=0, high=0, low=1 held → valvule stays 0 through edge 4 and is 1 after edge 5; fault=0.
- While filling, pulse high_water_level for 1 cycle at edge k → valvule=0 after edge k; it reopens no earlier than 17 cycles later, and only if low is still filtered 1.
- Low=1 held, high never asserts → valvule=1 for exactly 1024 cycles, then valvule=0, fault=1. fault_clear with conflicting=1 → still FAULT. fault_clear with conflicting=0 → fault=0, HOLDOFF for 16 cycles, then IDLE.
- 3-cycle low pulse from IDLE → f_low never rises and valvule stays 0. 4-cycle pulse → f_low rises.
- Assert reset for 1 cycle mid-FILLING (on_count=500) → valvule=0 after that edge; the subsequent open needs the full 5-edge latency.
- Conflict and timeout on the same edge (on_count=1023) → HOLDOFF, fault=0.

Source files
------------

// File: rtl/water_supply_pkg.sv
// Shared definitions for the water-supply valve scheduler: FSM state
// encoding and the default timing parameters.
package water_supply_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILLING = 2'd1,
        HOLDOFF = 2'd2,
        FAULT   = 2'd3
    } supply_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_MIN_OFF_CYCLES  = 16;
    localparam int DEFAULT_MAX_ON_CYCLES   = 1024;

endpackage

// File: rtl/water_level_debouncer.sv
// Single-line sensor debouncer. The filtered value only follows the raw
// line after DEBOUNCE_CYCLES consecutive samples that disagree with it.
module water_level_debouncer
    import water_supply_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic filtered
);

    localparam int            CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             filtered_q, filtered_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count disagreeing samples; adopt the raw value once the run is long enough.
    always_comb begin
        filtered_d = filtered_q;
        cnt_d      = '0;
        if (raw != filtered_q) begin
            if (cnt_q == CNT_LAST) begin
                filtered_d = raw;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Filter state register with synchronous reset to the safe value.
    always_ff @(posedge clock) begin
        if (reset) begin
            filtered_q <= RESET_VALUE;
            cnt_q      <= '0;
        end else begin
            filtered_q <= filtered_d;
            cnt_q      <= cnt_d;
        end
    end

    assign filtered = filtered_q;

endmodule

// File: rtl/water_supply_scheduler.sv
// Water-supply valve sequencer. Opens only on a clean debounced low-level
// reading, closes immediately on raw high level or sensor conflict, enforces
// a closed hold-off after every close and latches a fault on fill timeout.
module water_supply_scheduler
    import water_supply_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int MIN_OFF_CYCLES  = DEFAULT_MIN_OFF_CYCLES,
    parameter int MAX_ON_CYCLES   = DEFAULT_MAX_ON_CYCLES
) (
    input  logic clock,
    input  logic reset,
    output logic valvule,
    output logic fault,
    input  logic water_sensors_conflicting,
    input  logic high_water_level,
    input  logic low_water_level,
    input  logic fault_clear
);

    localparam int               ON_W     = $clog2(MAX_ON_CYCLES) + 1;
    localparam int               OFF_W    = $clog2(MIN_OFF_CYCLES) + 1;
    localparam logic [ON_W-1:0]  ON_LAST  = ON_W'(MAX_ON_CYCLES - 1);
    localparam logic [ON_W-1:0]  ON_MAX   = '1;
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(MIN_OFF_CYCLES - 1);
    localparam logic [OFF_W-1:0] OFF_MAX  = '1;

    logic f_conflicting, f_high, f_low;
    logic open_ok, close_now;

    supply_state_e    state_q, state_d;
    logic [ON_W-1:0]  on_count_q, on_count_d;
    logic [OFF_W-1:0] off_count_q, off_count_d;

    // Conflict filters start asserted so the valve stays shut until the
    // sensors have proven themselves clean after reset.
    water_level_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VALUE     (1'b1)
    ) u_conflict_db (
        .clock    (clock),
        .reset    (reset),
        .raw      (water_sensors_conflicting),
        .filtered (f_conflicting)
    );

    water_level_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VALUE     (1'b0)
    ) u_high_db (
        .clock    (clock),
        .reset    (reset),
        .raw      (high_water_level),
        .filtered (f_high)
    );

    water_level_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VALUE     (1'b0)
    ) u_low_db (
        .clock    (clock),
        .reset    (reset),
        .raw      (low_water_level),
        .filtered (f_low)
    );

    // Opening uses filtered values; closing uses raw values so a safety close is never delayed.
    assign open_ok   = f_low & ~f_high & ~f_conflicting;
    assign close_now = water_sensors_conflicting | high_water_level;

    // State and timer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            on_count_q  <= '0;
            off_count_q <= '0;
        end else begin
            state_q     <= state_d;
            on_count_q  <= on_count_d;
            off_count_q <= off_count_d;
        end
    end

    // Next-state and timer logic; each timer is zero outside its own state.
    always_comb begin
        state_d     = state_q;
        on_count_d  = '0;
        off_count_d = '0;
        case (state_q)
            IDLE: begin
                if (open_ok) begin
                    state_d = FILLING;
                end
            end
            FILLING: begin
                if (close_now) begin
                    state_d = HOLDOFF;
                end else if (on_count_q == ON_LAST) begin
                    state_d = FAULT;
                end else if (on_count_q != ON_MAX) begin
                    on_count_d = on_count_q + 1'b1;
                end else begin
                    on_count_d = on_count_q;
                end
            end
            HOLDOFF: begin
                if (off_count_q == OFF_LAST) begin
                    state_d = IDLE;
                end else if (off_count_q != OFF_MAX) begin
                    off_count_d = off_count_q + 1'b1;
                end else begin
                    off_count_d = off_count_q;
                end
            end
            FAULT: begin
                if (fault_clear && !water_sensors_conflicting) begin
                    state_d = HOLDOFF;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded purely from the state register.
    always_comb begin
        valvule = (state_q == FILLING);
        fault   = (state_q == FAULT);
    end

endmodule

// File: tb/tb_water_supply_scheduler.sv
// Directed self-checking bench for the water-supply valve scheduler.
module tb_water_supply_scheduler;

    logic clock;
    logic reset;
    logic valvule;
    logic fault;
    logic water_sensors_conflicting;
    logic high_water_level;
    logic low_water_level;
    logic fault_clear;

    int vectors;
    int miscompares;

    water_supply_scheduler #(
        .DEBOUNCE_CYCLES (4),
        .MIN_OFF_CYCLES  (16),
        .MAX_ON_CYCLES   (1024)
    ) dut (
        .clock                     (clock),
        .reset                     (reset),
        .valvule                   (valvule),
        .fault                     (fault),
        .water_sensors_conflicting (water_sensors_conflicting),
        .high_water_level          (high_water_level),
        .low_water_level           (low_water_level),
        .fault_clear               (fault_clear)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive all raw sensor inputs at once.
    task automatic applyStimulus(input logic conf, input logic high, input logic low, input logic clr);
        water_sensors_conflicting = conf;
        high_water_level          = high;
        low_water_level           = low;
        fault_clear               = clr;
    endtask

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    // Directed scenario sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(2);
        checkOutput("reset_valve", 32'(valvule), 32'd0);
        checkOutput("reset_fault", 32'(fault), 32'd0);

        reset = 1'b0;
        ticks(4);
        checkOutput("open_edge4", 32'(valvule), 32'd0);
        tick();
        checkOutput("open_edge5", 32'(valvule), 32'd1);
        checkOutput("open_fault", 32'(fault), 32'd0);

        ticks(10);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("close_latency", 32'(valvule), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(16);
        checkOutput("holdoff_min", 32'(valvule), 32'd0);
        tick();
        checkOutput("reopen", 32'(valvule), 32'd1);

        ticks(1023);
        checkOutput("max_on_last", 32'(valvule), 32'd1);
        checkOutput("max_on_nofault", 32'(fault), 32'd0);
        tick();
        checkOutput("timeout_valve", 32'(valvule), 32'd0);
        checkOutput("timeout_fault", 32'(fault), 32'd1);

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("clear_blocked", 32'(fault), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("clear_fault", 32'(fault), 32'd0);
        checkOutput("clear_valve", 32'(valvule), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(16);
        checkOutput("fault_holdoff", 32'(valvule), 32'd0);
        tick();
        checkOutput("refill_after_fault", 32'(valvule), 32'd1);

        ticks(100);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("stray_clear_valve", 32'(valvule), 32'd1);
        checkOutput("stray_clear_fault", 32'(fault), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(399);
        reset = 1'b1;
        tick();
        checkOutput("reset_midfill", 32'(valvule), 32'd0);
        reset = 1'b0;
        ticks(4);
        checkOutput("reopen_edge4", 32'(valvule), 32'd0);
        tick();
        checkOutput("reopen_edge5", 32'(valvule), 32'd1);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("close_for_idle", 32'(valvule), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(20);
        checkOutput("idle_low", 32'(valvule), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(8);
        checkOutput("glitch3", 32'(valvule), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(4);
        checkOutput("pulse4_edge4", 32'(valvule), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("pulse4_open", 32'(valvule), 32'd1);

        ticks(1023);
        checkOutput("simul_before", 32'(valvule), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("simul_valve", 32'(valvule), 32'd0);
        checkOutput("simul_fault", 32'(fault), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(20);
        checkOutput("simul_settle_fault", 32'(fault), 32'd0);
        checkOutput("simul_settle_valve", 32'(valvule), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
